// File: rtl/mc_sequencer_pkg.sv
// Shared definitions for the multi-cycle sequencer: state encoding, opcode
// classes and trap cause codes.
package mc_sequencer_pkg;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_TRAP   = 3'd5
   } state_e;

   localparam logic [4:0] OP_R      = 5'b01100;
   localparam logic [4:0] OP_IMM    = 5'b00100;
   localparam logic [4:0] OP_LOAD   = 5'b00000;
   localparam logic [4:0] OP_STORE  = 5'b01000;
   localparam logic [4:0] OP_BRANCH = 5'b11000;
   localparam logic [4:0] OP_JALR   = 5'b11001;
   localparam logic [4:0] OP_JAL    = 5'b11011;
   localparam logic [4:0] OP_LUI    = 5'b01101;
   localparam logic [4:0] OP_AUIPC  = 5'b00101;

   localparam logic [1:0] CAUSE_NONE    = 2'b00;
   localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
   localparam logic [1:0] CAUSE_IMEM    = 2'b10;
   localparam logic [1:0] CAUSE_DMEM    = 2'b11;

   typedef struct packed {
      logic is_mem;
      logic is_store;
      logic is_legal;
   } opclass_t;

endpackage

// File: rtl/mc_opclass.sv
// Combinational opcode classifier: tells the sequencer whether the latched
// instruction is legal and whether it needs a data-memory access.
module mc_opclass
   import mc_sequencer_pkg::*;
(
   input  logic [8:0] operation_key,
   output opclass_t   op_class
);

   logic [4:0] opcode;
   logic       unused_funct;

   assign opcode       = operation_key[4:0];
   // funct bits matter to the ALU decode, not to sequencing
   assign unused_funct = ^operation_key[8:5];

   always_comb begin
      op_class = '0;
      case (opcode)
         OP_LOAD: begin
            op_class.is_mem   = 1'b1;
            op_class.is_legal = 1'b1;
         end
         OP_STORE: begin
            op_class.is_mem   = 1'b1;
            op_class.is_store = 1'b1;
            op_class.is_legal = 1'b1;
         end
         OP_R, OP_IMM, OP_BRANCH, OP_JALR, OP_JAL, OP_LUI, OP_AUIPC: begin
            op_class.is_legal = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mc_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with memory handshakes,
// wait timeouts, a sticky trap and cycle/instret counters.
module mc_sequencer
   import mc_sequencer_pkg::*;
#(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [8:0]       operation_key,
   input  logic             reg_wen,
   input  logic             mem_rw,
   input  logic             imem_ready,
   input  logic             dmem_ready,
   output logic             imem_req,
   output logic             ir_load,
   output logic             pc_write,
   output logic             rf_we,
   output logic             dmem_req,
   output logic             dmem_we,
   output logic             retire,
   output logic             trap,
   output logic [1:0]       trap_cause,
   output logic [2:0]       state_o,
   output logic [CNT_W-1:0] cycle_count,
   output logic [CNT_W-1:0] instret_count
);

   localparam int                WAIT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

   state_e            state, next_state;
   logic [WAIT_W-1:0] wait_cnt, wait_nxt;
   opclass_t          op_class;
   logic              trap_set;
   logic [1:0]        cause_nxt;
   logic              imem_req_c, ir_load_c, pc_write_c, rf_we_c;
   logic              dmem_req_c, dmem_we_c, retire_c;

   mc_opclass u_opclass (
      .operation_key (operation_key),
      .op_class      (op_class)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= S_FETCH;
         wait_cnt      <= '0;
         trap          <= 1'b0;
         trap_cause    <= CAUSE_NONE;
         cycle_count   <= '0;
         instret_count <= '0;
      end else begin
         state       <= next_state;
         wait_cnt    <= wait_nxt;
         cycle_count <= cycle_count + 1'b1;
         if (trap_set) begin
            trap       <= 1'b1;
            trap_cause <= cause_nxt;
         end
         if (retire_c) instret_count <= instret_count + 1'b1;
      end
   end

   always_comb begin
      next_state = state;
      trap_set   = 1'b0;
      cause_nxt  = CAUSE_NONE;
      imem_req_c = 1'b0;
      ir_load_c  = 1'b0;
      pc_write_c = 1'b0;
      rf_we_c    = 1'b0;
      dmem_req_c = 1'b0;
      dmem_we_c  = 1'b0;
      retire_c   = 1'b0;
      case (state)
         S_FETCH: begin
            imem_req_c = 1'b1;
            // ready wins over a timeout in the same cycle
            if (imem_ready) begin
               ir_load_c  = 1'b1;
               next_state = S_DECODE;
            end else if (wait_cnt == WAIT_LAST) begin
               next_state = S_TRAP;
               trap_set   = 1'b1;
               cause_nxt  = CAUSE_IMEM;
            end
         end
         S_DECODE: begin
            if (!op_class.is_legal) begin
               next_state = S_TRAP;
               trap_set   = 1'b1;
               cause_nxt  = CAUSE_ILLEGAL;
            end else begin
               next_state = S_EXEC;
            end
         end
         S_EXEC: next_state = op_class.is_mem ? S_MEM : S_WB;
         S_MEM: begin
            dmem_req_c = 1'b1;
            dmem_we_c  = mem_rw;
            if (dmem_ready) begin
               if (op_class.is_store) begin
                  pc_write_c = 1'b1;
                  retire_c   = 1'b1;
                  next_state = S_FETCH;
               end else begin
                  next_state = S_WB;
               end
            end else if (wait_cnt == WAIT_LAST) begin
               next_state = S_TRAP;
               trap_set   = 1'b1;
               cause_nxt  = CAUSE_DMEM;
            end
         end
         S_WB: begin
            rf_we_c    = reg_wen;
            pc_write_c = 1'b1;
            retire_c   = 1'b1;
            next_state = S_FETCH;
         end
         S_TRAP: ;
         default: next_state = S_FETCH;
      endcase
   end

   always_comb begin
      wait_nxt = '0;
      if (next_state == state && (state == S_FETCH || state == S_MEM))
         wait_nxt = wait_cnt + 1'b1;
   end

   // Strobes are forced low while rst is high so an abandoned access drops at once
   assign imem_req = imem_req_c & ~rst;
   assign ir_load  = ir_load_c  & ~rst;
   assign pc_write = pc_write_c & ~rst;
   assign rf_we    = rf_we_c    & ~rst;
   assign dmem_req = dmem_req_c & ~rst;
   assign dmem_we  = dmem_we_c  & ~rst;
   assign retire   = retire_c   & ~rst;
   assign state_o  = state;

endmodule

// File: tb/tb_mc_sequencer.sv
// Randomized self-checking bench for mc_sequencer against a per-instruction
// cycle-trace model.
module tb_mc_sequencer;

   localparam int TO = 4;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [8:0]    operation_key = '0;
   logic          reg_wen = 1'b0;
   logic          mem_rw = 1'b0;
   logic          imem_ready = 1'b0;
   logic          dmem_ready = 1'b0;
   logic          imem_req, ir_load, pc_write, rf_we, dmem_req, dmem_we, retire, trap;
   logic [1:0]    trap_cause;
   logic [2:0]    state_o;
   logic [CW-1:0] cycle_count, instret_count;

   mc_sequencer #(.TIMEOUT(TO), .CNT_W(CW)) dut (
      .clk           (clk),
      .rst           (rst),
      .operation_key (operation_key),
      .reg_wen       (reg_wen),
      .mem_rw        (mem_rw),
      .imem_ready    (imem_ready),
      .dmem_ready    (dmem_ready),
      .imem_req      (imem_req),
      .ir_load       (ir_load),
      .pc_write      (pc_write),
      .rf_we         (rf_we),
      .dmem_req      (dmem_req),
      .dmem_we       (dmem_we),
      .retire        (retire),
      .trap          (trap),
      .trap_cause    (trap_cause),
      .state_o       (state_o),
      .cycle_count   (cycle_count),
      .instret_count (instret_count)
   );

   always #5 clk = ~clk;

   // outs = {state[2:0], imem_req, ir_load, pc_write, rf_we, dmem_req, dmem_we, retire, trap, cause[1:0]}
   typedef struct {
      logic [12:0] outs;
      logic        irdy;
      logic        drdy;
   } rec_t;

   rec_t        exp_q[$];
   logic [12:0] exp_o[$];
   logic [12:0] obs_q[$];
   int          checks = 0;
   int          failures = 0;
   int          m_cycles = 0;
   int          m_instret = 0;

   function automatic logic [12:0] obs();
      return {state_o, imem_req, ir_load, pc_write, rf_we, dmem_req, dmem_we, retire, trap, trap_cause};
   endfunction

   function automatic bit rb();
      return bit'($urandom & 32'd1);
   endfunction

   function automatic void rec(int st, logic [6:0] str, bit tr, int cause, bit irdy, bit drdy);
      rec_t r;
      r.outs = {st[2:0], str, tr, cause[1:0]};
      r.irdy = irdy;
      r.drdy = drdy;
      exp_q.push_back(r);
   endfunction

   function automatic bit legal_op(logic [4:0] op);
      return op inside {5'b01100, 5'b00100, 5'b00000, 5'b01000, 5'b11000,
                        5'b11001, 5'b11011, 5'b01101, 5'b00101};
   endfunction

   // Expected trace of one instruction; fd/md = cycles before imem/dmem ready. Returns trap cause.
   function automatic int build_instr(logic [4:0] op, bit wen, bit mrw, int fd, int md);
      bit mem_c = (op == 5'b00000) || (op == 5'b01000);
      bit st_c  = (op == 5'b01000);
      for (int i = 0; i < TO; i++) begin
         if (i == fd) begin
            rec(0, 7'b1100000, 1'b0, 0, 1'b1, rb());
            break;
         end
         rec(0, 7'b1000000, 1'b0, 0, 1'b0, rb());
      end
      if (fd >= TO) return 2;
      rec(1, 7'b0, 1'b0, 0, rb(), rb());
      if (!legal_op(op)) return 1;
      rec(2, 7'b0, 1'b0, 0, rb(), rb());
      if (mem_c) begin
         for (int i = 0; i < TO; i++) begin
            if (i == md) begin
               rec(3, {2'b00, st_c, 1'b0, 1'b1, mrw, st_c}, 1'b0, 0, rb(), 1'b1);
               break;
            end
            rec(3, {4'b0000, 1'b1, mrw, 1'b0}, 1'b0, 0, rb(), 1'b0);
         end
         if (md >= TO) return 3;
         if (st_c) return 0;
      end
      rec(4, {3'b001, wen, 3'b001}, 1'b0, 0, rb(), rb());
      return 0;
   endfunction

   function automatic void push_trap(int cause, int n);
      for (int i = 0; i < n; i++) rec(5, 7'b0, 1'b1, cause, rb(), rb());
   endfunction

   task automatic play(int n);
      rec_t r;
      int   k = 0;
      while (exp_q.size() > 0 && k < n) begin
         r = exp_q.pop_front();
         imem_ready = r.irdy;
         dmem_ready = r.drdy;
         @(negedge clk);
         obs_q.push_back(obs());
         exp_o.push_back(r.outs);
         m_cycles++;
         if (r.outs[3]) m_instret++;
         @(posedge clk);
         #1;
         k++;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      m_cycles = 0;
      m_instret = 0;
      exp_q.delete();
      exp_o.delete();
      obs_q.delete();
   endtask

   task automatic test_reset();
      imem_ready = 1'b1;
      dmem_ready = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (obs() !== 13'd0) begin
         failures++;
         $display("FAIL reset_outputs got=%h exp=%h", obs(), 13'd0);
      end
      checks++;
      if (cycle_count !== '0 || instret_count !== '0) begin
         failures++;
         $display("FAIL reset_counters got=%0d/%0d exp=0/0", cycle_count, instret_count);
      end
      do_reset();
      imem_ready = 1'b0;
      #2;
      checks++;
      if (imem_req !== 1'b1 || state_o !== 3'd0) begin
         failures++;
         $display("FAIL reset_release got=req%b st%0d exp=req1 st0", imem_req, state_o);
      end
   endtask

   task automatic test_add();
      do_reset();
      operation_key = 9'b0_000_01100;
      reg_wen = 1'b1;
      mem_rw = 1'b0;
      void'(build_instr(5'b01100, 1'b1, 1'b0, 0, 0));
      play(100);
      foreach (obs_q[i]) begin
         checks++;
         if (obs_q[i] !== exp_o[i]) begin
            failures++;
            $display("FAIL add cyc%0d got=%h exp=%h", i, obs_q[i], exp_o[i]);
         end
      end
      checks++;
      if (instret_count !== 4'd1 || cycle_count !== 4'd4) begin
         failures++;
         $display("FAIL add_counts got=%0d/%0d exp=1/4", instret_count, cycle_count);
      end
   endtask

   task automatic test_load();
      do_reset();
      operation_key = 9'b0_010_00000;
      reg_wen = 1'b1;
      mem_rw = 1'b0;
      void'(build_instr(5'b00000, 1'b1, 1'b0, 0, 3));
      play(100);
      foreach (obs_q[i]) begin
         checks++;
         if (obs_q[i] !== exp_o[i]) begin
            failures++;
            $display("FAIL load cyc%0d got=%h exp=%h", i, obs_q[i], exp_o[i]);
         end
      end
      checks++;
      if (instret_count !== 4'd1 || cycle_count !== 4'd8) begin
         failures++;
         $display("FAIL load_counts got=%0d/%0d exp=1/8", instret_count, cycle_count);
      end
   endtask

   task automatic test_store();
      do_reset();
      operation_key = 9'b0_010_01000;
      reg_wen = 1'b1;
      mem_rw = 1'b1;
      void'(build_instr(5'b01000, 1'b1, 1'b1, 1, 0));
      play(100);
      foreach (obs_q[i]) begin
         checks++;
         if (obs_q[i] !== exp_o[i]) begin
            failures++;
            $display("FAIL store cyc%0d got=%h exp=%h", i, obs_q[i], exp_o[i]);
         end
      end
      checks++;
      if (instret_count !== 4'(m_instret) || cycle_count !== 4'(m_cycles)) begin
         failures++;
         $display("FAIL store_counts got=%0d/%0d exp=%0d/%0d", instret_count, cycle_count, m_instret, m_cycles);
      end
   endtask

   task automatic test_illegal();
      int cause;
      do_reset();
      operation_key = 9'b0_000_11111;
      reg_wen = 1'b1;
      mem_rw = 1'b0;
      cause = build_instr(5'b11111, 1'b1, 1'b0, 0, 0);
      push_trap(cause, 5);
      play(100);
      foreach (obs_q[i]) begin
         checks++;
         if (obs_q[i] !== exp_o[i]) begin
            failures++;
            $display("FAIL illegal cyc%0d got=%h exp=%h", i, obs_q[i], exp_o[i]);
         end
      end
      checks++;
      if (instret_count !== 4'd0 || cycle_count !== 4'(m_cycles)) begin
         failures++;
         $display("FAIL illegal_counts got=%0d/%0d exp=0/%0d", instret_count, cycle_count, m_cycles);
      end
      do_reset();
      #2;
      checks++;
      if (trap !== 1'b0 || trap_cause !== 2'b00) begin
         failures++;
         $display("FAIL trap_clear got=%b/%b exp=0/00", trap, trap_cause);
      end
   endtask

   task automatic test_imem_timeout();
      int cause;
      do_reset();
      operation_key = 9'b0_000_01100;
      reg_wen = 1'b1;
      mem_rw = 1'b0;
      void'(build_instr(5'b01100, 1'b1, 1'b0, TO - 1, 0));
      play(100);
      cause = build_instr(5'b01100, 1'b1, 1'b0, TO, 0);
      push_trap(cause, 3);
      play(100);
      foreach (obs_q[i]) begin
         checks++;
         if (obs_q[i] !== exp_o[i]) begin
            failures++;
            $display("FAIL imem_to cyc%0d got=%h exp=%h", i, obs_q[i], exp_o[i]);
         end
      end
      checks++;
      if (trap_cause !== 2'b10 || instret_count !== 4'd1 || cycle_count !== 4'(m_cycles)) begin
         failures++;
         $display("FAIL imem_to_state got=%b/%0d/%0d exp=10/1/%0d", trap_cause, instret_count, cycle_count, m_cycles);
      end
   endtask

   task automatic test_dmem_timeout();
      int cause;
      do_reset();
      operation_key = 9'b0_010_00000;
      reg_wen = 1'b1;
      mem_rw = 1'b0;
      void'(build_instr(5'b00000, 1'b1, 1'b0, 0, TO - 1));
      play(100);
      cause = build_instr(5'b00000, 1'b1, 1'b0, 0, TO);
      push_trap(cause, 3);
      play(100);
      foreach (obs_q[i]) begin
         checks++;
         if (obs_q[i] !== exp_o[i]) begin
            failures++;
            $display("FAIL dmem_to cyc%0d got=%h exp=%h", i, obs_q[i], exp_o[i]);
         end
      end
      checks++;
      if (trap_cause !== 2'b11 || instret_count !== 4'd1 || cycle_count !== 4'(m_cycles)) begin
         failures++;
         $display("FAIL dmem_to_state got=%b/%0d/%0d exp=11/1/%0d", trap_cause, instret_count, cycle_count, m_cycles);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      operation_key = 9'b0_000_01100;
      reg_wen = 1'b1;
      mem_rw = 1'b0;
      for (int n = 0; n < 16; n++) begin
         void'(build_instr(5'b01100, 1'b1, 1'b0, 0, 0));
         play(100);
      end
      foreach (obs_q[i]) begin
         checks++;
         if (obs_q[i] !== exp_o[i]) begin
            failures++;
            $display("FAIL b2b cyc%0d got=%h exp=%h", i, obs_q[i], exp_o[i]);
         end
      end
      checks++;
      if (instret_count !== 4'd0 || m_instret != 16) begin
         failures++;
         $display("FAIL instret_wrap got=%0d exp=0 (retired %0d)", instret_count, m_instret);
      end
      checks++;
      if (cycle_count !== 4'(m_cycles)) begin
         failures++;
         $display("FAIL cycle_wrap got=%0d exp=%0d", cycle_count, 4'(m_cycles));
      end
   endtask

   task automatic test_random();
      logic [4:0] ops [9] = '{5'b01100, 5'b00100, 5'b00000, 5'b01000, 5'b11000,
                              5'b11001, 5'b11011, 5'b01101, 5'b00101};
      logic [4:0] op;
      bit         wen;
      do_reset();
      for (int n = 0; n < 30; n++) begin
         op  = ops[$urandom_range(8, 0)];
         wen = rb();
         operation_key = {4'($urandom), op};
         reg_wen = wen;
         mem_rw = (op == 5'b01000);
         void'(build_instr(op, wen, op == 5'b01000, $urandom_range(TO - 1, 0), $urandom_range(TO - 1, 0)));
         play(100);
      end
      foreach (obs_q[i]) begin
         checks++;
         if (obs_q[i] !== exp_o[i]) begin
            failures++;
            $display("FAIL random cyc%0d got=%h exp=%h", i, obs_q[i], exp_o[i]);
         end
      end
      checks++;
      if (instret_count !== 4'(m_instret) || cycle_count !== 4'(m_cycles)) begin
         failures++;
         $display("FAIL random_counts got=%0d/%0d exp=%0d/%0d", instret_count, cycle_count, 4'(m_instret), 4'(m_cycles));
      end
   endtask

   task automatic test_rst_mid_mem();
      do_reset();
      operation_key = 9'b0_010_00000;
      reg_wen = 1'b1;
      mem_rw = 1'b0;
      void'(build_instr(5'b00000, 1'b1, 1'b0, 0, 3));
      play(5);
      dmem_ready = 1'b0;
      #1;
      checks++;
      if (dmem_req !== 1'b1 || state_o !== 3'd3) begin
         failures++;
         $display("FAIL pre_rst_mem got=req%b st%0d exp=req1 st3", dmem_req, state_o);
      end
      #1 rst = 1'b1;
      #1;
      checks++;
      if (dmem_req !== 1'b0 || imem_req !== 1'b0 || state_o !== 3'd0) begin
         failures++;
         $display("FAIL rst_mid_mem got=dreq%b ireq%b st%0d exp=0/0/0", dmem_req, imem_req, state_o);
      end
      checks++;
      if (cycle_count !== '0 || instret_count !== '0) begin
         failures++;
         $display("FAIL rst_mid_mem_counts got=%0d/%0d exp=0/0", cycle_count, instret_count);
      end
      do_reset();
   endtask

   initial begin
      test_reset();
      test_add();
      test_load();
      test_store();
      test_illegal();
      test_imem_timeout();
      test_dmem_timeout();
      test_back_to_back();
      test_random();
      test_rst_mid_mem();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
